// File: rtl/mul_mdc_stream_sequencer.sv
// ---------------------------------------------------------------------------
// mul_mdc_stream_sequencer
//
// Tile-level sequencer for the mul_mdc streamer (sources a/b/c, sink d).
// A job descriptor is latched on start_i. The block then loops over
// n_tiles tiles: it issues one start request per stream, waits for every
// stream to report done, and advances all base addresses by tile_stride.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clear_i                synchronous clear, same effect as reset
//   start_i                job start pulse, only sampled in IDLE
//   base_addr_i            per-stream base address, slice NB_SRC is the sink
//   trans_size_i           words per tile per stream
//   n_tiles_i              number of tiles in the job
//   tile_stride_i          byte offset added to every base address per tile
//   src_ready_start_i      source address generators ready for a start
//   sink_ready_start_i     sink address generator ready for a start
//   src_done_i             one-cycle source done pulses
//   sink_done_i            one-cycle sink done pulse
//   src_req_start_o        one-cycle start request per source
//   sink_req_start_o       one-cycle start request to the sink
//   addr_o                 current tile base address per stream
//   trans_size_o           latched transfer size
//   tile_idx_o             index of the tile in flight
//   busy_o                 high from the cycle after an accepted start
//                          through the DONE state
//   done_o                 one-cycle pulse at the end of a job
//   dbg_state_o            current FSM state (debug observation only)
//
// Start handshake (all streams): ready_start[k] is sampled in ISSUE; the
// request pulse req_start[k] follows one cycle later (it is registered),
// so an address generator must keep ready_start high until it sees its
// request. A stream receives exactly one request per tile, no matter how
// long ready_start stays high. Done pulses only count once the request of
// the current tile has been issued in an earlier cycle.
// ---------------------------------------------------------------------------
module mul_mdc_stream_sequencer #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned SIZE_WIDTH = 16,
    parameter int unsigned NB_SRC     = 3
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic                           start_i,
    input  logic [(NB_SRC+1)*ADDR_WIDTH-1:0] base_addr_i,
    input  logic [SIZE_WIDTH-1:0]          trans_size_i,
    input  logic [SIZE_WIDTH-1:0]          n_tiles_i,
    input  logic [ADDR_WIDTH-1:0]          tile_stride_i,
    input  logic [NB_SRC-1:0]              src_ready_start_i,
    input  logic                           sink_ready_start_i,
    input  logic [NB_SRC-1:0]              src_done_i,
    input  logic                           sink_done_i,
    output logic [NB_SRC-1:0]              src_req_start_o,
    output logic                           sink_req_start_o,
    output logic [(NB_SRC+1)*ADDR_WIDTH-1:0] addr_o,
    output logic [SIZE_WIDTH-1:0]          trans_size_o,
    output logic [SIZE_WIDTH-1:0]          tile_idx_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic [2:0]                     dbg_state_o
);

    localparam int unsigned NB_STR = NB_SRC + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    state_e                         state_q,  state_d;
    logic [NB_STR-1:0]              issued_q, issued_d;
    logic [NB_STR-1:0]              dmask_q,  dmask_d;
    logic [NB_STR-1:0]              req_q,    req_d;
    logic [NB_STR*ADDR_WIDTH-1:0]   addr_q,   addr_d;
    logic [SIZE_WIDTH-1:0]          size_q,   size_d;
    logic [SIZE_WIDTH-1:0]          ntiles_q, ntiles_d;
    logic [ADDR_WIDTH-1:0]          stride_q, stride_d;
    logic [SIZE_WIDTH-1:0]          tile_q,   tile_d;
    logic                           busy_q,   busy_d;
    logic                           done_q,   done_d;

    // Stream vectors with the sink in the top bit.
    logic [NB_STR-1:0] ready_all;
    logic [NB_STR-1:0] done_all;
    logic [NB_STR-1:0] fire;

    assign ready_all = {sink_ready_start_i, src_ready_start_i};
    assign done_all  = {sink_done_i, src_done_i};

    always_comb begin
        state_d  = state_q;
        issued_d = issued_q;
        dmask_d  = dmask_q;
        req_d    = '0;
        addr_d   = addr_q;
        size_d   = size_q;
        ntiles_d = ntiles_q;
        stride_d = stride_q;
        tile_d   = tile_q;
        fire     = '0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    size_d   = trans_size_i;
                    ntiles_d = n_tiles_i;
                    stride_d = tile_stride_i;
                    addr_d   = base_addr_i;
                    tile_d   = '0;
                    // An empty job finishes without touching the streams.
                    state_d  = (n_tiles_i != '0) ? ST_ISSUE : ST_DONE;
                end
            end

            ST_ISSUE: begin
                fire     = ~issued_q & ready_all;
                req_d    = fire;
                issued_d = issued_q | fire;
                // Only streams issued in an earlier cycle may complete.
                dmask_d  = dmask_q | (done_all & issued_q);
                if (&issued_d) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                dmask_d = dmask_q | (done_all & issued_q);
                if (&dmask_d) begin
                    state_d = ST_NEXT;
                end
            end

            ST_NEXT: begin
                issued_d = '0;
                dmask_d  = '0;
                if (tile_q == ntiles_q - SIZE_WIDTH'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    tile_d = tile_q + SIZE_WIDTH'(1);
                    // Addresses wrap modulo 2^ADDR_WIDTH.
                    for (int k = 0; k < int'(NB_STR); k++) begin
                        addr_d[k*ADDR_WIDTH +: ADDR_WIDTH] =
                            addr_q[k*ADDR_WIDTH +: ADDR_WIDTH] + stride_q;
                    end
                    state_d = ST_ISSUE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear overrides every other event, including mid-job.
        if (clear_i) begin
            state_d  = ST_IDLE;
            issued_d = '0;
            dmask_d  = '0;
            req_d    = '0;
            addr_d   = '0;
            size_d   = '0;
            ntiles_d = '0;
            stride_d = '0;
            tile_d   = '0;
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            issued_q <= '0;
            dmask_q  <= '0;
            req_q    <= '0;
            addr_q   <= '0;
            size_q   <= '0;
            ntiles_q <= '0;
            stride_q <= '0;
            tile_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            issued_q <= issued_d;
            dmask_q  <= dmask_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            ntiles_q <= ntiles_d;
            stride_q <= stride_d;
            tile_q   <= tile_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign src_req_start_o  = req_q[NB_SRC-1:0];
    assign sink_req_start_o = req_q[NB_SRC];
    assign addr_o           = addr_q;
    assign trans_size_o     = size_q;
    assign tile_idx_o       = tile_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_mul_mdc_stream_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mul_mdc_stream_sequencer
//
// Scoreboard bench: every job pushes the per-stream start requests it must
// produce (tile index and tile address from base + t*stride) and one job
// completion record. Stream responders model the address generators
// (ready delays, done delays, stray done pulses); a monitor pops and
// compares whenever the sequencer raises a request or done_o.
// ---------------------------------------------------------------------------
module tb_mul_mdc_stream_sequencer;

    localparam int AW = 32;
    localparam int SW = 16;
    localparam int NS = 3;
    localparam int NT = NS + 1;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic                 clear_i;
    logic                 start_i;
    logic [NT*AW-1:0]     base_addr_i;
    logic [SW-1:0]        trans_size_i;
    logic [SW-1:0]        n_tiles_i;
    logic [AW-1:0]        tile_stride_i;
    logic [NS-1:0]        src_ready_start_i;
    logic                 sink_ready_start_i;
    logic [NS-1:0]        src_done_i;
    logic                 sink_done_i;
    logic [NS-1:0]        src_req_start_o;
    logic                 sink_req_start_o;
    logic [NT*AW-1:0]     addr_o;
    logic [SW-1:0]        trans_size_o;
    logic [SW-1:0]        tile_idx_o;
    logic                 busy_o;
    logic                 done_o;
    logic [2:0]           dbg_state_o;

    mul_mdc_stream_sequencer #(
        .ADDR_WIDTH (AW),
        .SIZE_WIDTH (SW),
        .NB_SRC     (NS)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .clear_i            (clear_i),
        .start_i            (start_i),
        .base_addr_i        (base_addr_i),
        .trans_size_i       (trans_size_i),
        .n_tiles_i          (n_tiles_i),
        .tile_stride_i      (tile_stride_i),
        .src_ready_start_i  (src_ready_start_i),
        .sink_ready_start_i (sink_ready_start_i),
        .src_done_i         (src_done_i),
        .sink_done_i        (sink_done_i),
        .src_req_start_o    (src_req_start_o),
        .sink_req_start_o   (sink_req_start_o),
        .addr_o             (addr_o),
        .trans_size_o       (trans_size_o),
        .tile_idx_o         (tile_idx_o),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .dbg_state_o        (dbg_state_o)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [SW-1:0]    tile;
        logic [NT*AW-1:0] addr;
        logic [SW-1:0]    size;
        logic [31:0]      cyc;   // 0: completion cycle not checked
    } job_t;

    job_t        exp_q[$];
    logic [47:0] req_q0[$];
    logic [47:0] req_q1[$];
    logic [47:0] req_q2[$];
    logic [47:0] req_q3[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_req(input int k, input logic [47:0] v);
        case (k)
            0: req_q0.push_back(v);
            1: req_q1.push_back(v);
            2: req_q2.push_back(v);
            default: req_q3.push_back(v);
        endcase
    endtask

    task automatic pop_req(input int k, output bit ok, output logic [47:0] v);
        ok = 1'b0;
        v  = '0;
        case (k)
            0: if (req_q0.size() != 0) begin v = req_q0.pop_front(); ok = 1'b1; end
            1: if (req_q1.size() != 0) begin v = req_q1.pop_front(); ok = 1'b1; end
            2: if (req_q2.size() != 0) begin v = req_q2.pop_front(); ok = 1'b1; end
            default: if (req_q3.size() != 0) begin v = req_q3.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic flush_reqs();
        req_q0.delete();
        req_q1.delete();
        req_q2.delete();
        req_q3.delete();
    endtask

    // ---------------- stream responders ----------------
    int ready_lo[NT];
    int ready_hi[NT];
    int done_lo;
    int done_hi;
    bit spur_en;
    bit resp_flush;
    bit outstanding[NT];
    int dcnt[NT];
    int rcnt[NT];

    initial begin
        logic [NT-1:0] req;
        logic [NT-1:0] dn;
        logic [NT-1:0] rdy;
        src_ready_start_i  = '0;
        sink_ready_start_i = 1'b0;
        src_done_i         = '0;
        sink_done_i        = 1'b0;
        for (int k = 0; k < NT; k++) begin
            outstanding[k] = 1'b0;
            dcnt[k]        = 0;
            rcnt[k]        = 0;
        end
        forever begin
            @(posedge clk_i);
            #2;
            req = {sink_req_start_o, src_req_start_o};
            dn  = '0;
            rdy = '0;
            for (int k = 0; k < NT; k++) begin
                if (resp_flush) begin
                    outstanding[k] = 1'b0;
                    rcnt[k] = int'($urandom_range(ready_hi[k], ready_lo[k]));
                end else begin
                    if (req[k]) begin
                        outstanding[k] = 1'b1;
                        dcnt[k] = int'($urandom_range(done_hi, done_lo));
                        rcnt[k] = int'($urandom_range(ready_hi[k], ready_lo[k]));
                    end
                    if (outstanding[k]) begin
                        if (dcnt[k] == 0) begin
                            dn[k] = 1'b1;
                            outstanding[k] = 1'b0;
                        end else begin
                            dcnt[k]--;
                        end
                    end else if (spur_en && $urandom_range(0, 7) == 0) begin
                        dn[k] = 1'b1;   // stray pulse from an idle stream
                    end
                end
                rdy[k] = (rcnt[k] == 0);
                if (rcnt[k] > 0) rcnt[k]--;
            end
            src_ready_start_i  = rdy[NS-1:0];
            sink_ready_start_i = rdy[NS];
            src_done_i         = dn[NS-1:0];
            sink_done_i        = dn[NS];
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [NT-1:0] req;
        logic [47:0]   v;
        bit            ok;
        job_t          e;
        forever begin
            @(posedge clk_i);
            #2;
            req = {sink_req_start_o, src_req_start_o};
            for (int k = 0; k < NT; k++) begin
                if (req[k]) begin
                    pop_req(k, ok, v);
                    check($sformatf("req_s%0d_expected", k), 128'(ok), 128'(1));
                    if (ok) begin
                        check($sformatf("req_s%0d_tile", k), 128'(tile_idx_o), 128'(v[47:32]));
                        check($sformatf("req_s%0d_addr", k), 128'(addr_o[k*AW +: AW]), 128'(v[31:0]));
                    end
                end
            end
            if (done_o) begin
                check("done_expected", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("done_tile_idx", 128'(tile_idx_o), 128'(e.tile));
                    check("done_addr", 128'(addr_o), 128'(e.addr));
                    check("done_trans_size", 128'(trans_size_o), 128'(e.size));
                    check("done_busy", 128'(busy_o), 128'(1));
                    if (e.cyc != 0) check("done_latency", 128'(cyc), 128'(e.cyc));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic flush_cycle();
        resp_flush = 1'b1;
        @(posedge clk_i);
        #1;
        resp_flush = 1'b0;
    endtask

    task automatic scramble_cfg();
        base_addr_i   = {$urandom, $urandom, $urandom, $urandom};
        trans_size_i  = SW'($urandom);
        n_tiles_i     = SW'($urandom);
        tile_stride_i = $urandom;
    endtask

    // Issues start in the current cycle and pushes all expectations.
    task automatic issue_job(input logic [NT*AW-1:0] base, input logic [SW-1:0] sz,
                             input logic [SW-1:0] n, input logic [AW-1:0] stride,
                             input bit chk_lat, input bit push_done);
        logic [AW-1:0]    a;
        logic [NT*AW-1:0] fin;
        job_t             e;
        int               last;
        for (int t = 0; t < int'(n); t++) begin
            for (int k = 0; k < NT; k++) begin
                a = base[k*AW +: AW] + AW'(t) * stride;
                push_req(k, {SW'(t), a});
            end
        end
        last = (n == 0) ? 0 : int'(n) - 1;
        for (int k = 0; k < NT; k++) fin[k*AW +: AW] = base[k*AW +: AW] + AW'(last) * stride;
        base_addr_i   = base;
        trans_size_i  = sz;
        n_tiles_i     = n;
        tile_stride_i = stride;
        start_i       = 1'b1;
        e.tile = SW'(last);
        e.addr = fin;
        e.size = sz;
        e.cyc  = chk_lat ? (cyc + 1 + 3 * int'(n)) : 0;
        if (push_done) exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        scramble_cfg();
    endtask

    task automatic run_job(input logic [NT*AW-1:0] base, input logic [SW-1:0] sz,
                           input logic [SW-1:0] n, input logic [AW-1:0] stride,
                           input bit chk_lat, input bit noise);
        flush_cycle();
        issue_job(base, sz, n, stride, chk_lat, 1'b1);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) begin
            start_i = 1'b0;
            if (noise) begin
                scramble_cfg();
                // Only while the last sink request is still pending is the
                // sequencer guaranteed to be mid-job.
                if (req_q3.size() != 0 && $urandom_range(0, 3) == 0) start_i = 1'b1;
            end
            @(posedge clk_i);
            #1;
        end
        start_i = 1'b0;
        check("job_finished", 128'(exp_q.size() == 0), 128'(1));
        check("busy_after_done", 128'(busy_o), 128'(0));
        check("reqs_all_seen", 128'(req_q0.size() + req_q1.size() + req_q2.size() + req_q3.size()), 128'(0));
        exp_q.delete();
        flush_reqs();
    endtask

    task automatic set_resp(input int r0, input int r1, input int r2, input int r3,
                            input int dlo, input int dhi, input bit spur);
        ready_lo[0] = r0; ready_hi[0] = r0;
        ready_lo[1] = r1; ready_hi[1] = r1;
        ready_lo[2] = r2; ready_hi[2] = r2;
        ready_lo[3] = r3; ready_hi[3] = r3;
        done_lo = dlo;
        done_hi = dhi;
        spur_en = spur;
    endtask

    task automatic clear_mid_job();
        set_resp(0, 0, 0, 0, 8, 8, 1'b0);
        flush_cycle();
        issue_job({32'h4000, 32'h3000, 32'h2000, 32'h1000}, 16'd4, 16'd3, 32'h40, 1'b0, 1'b0);
        for (int i = 0; i < 200 && req_q3.size() > 1; i++) begin
            @(posedge clk_i);
            #1;
        end
        check("clear_reached_tile1", 128'(req_q3.size()), 128'(1));
        repeat (2) begin
            @(posedge clk_i);
            #1;
        end
        clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        flush_reqs();
        check("clear_req", 128'({sink_req_start_o, src_req_start_o}), 128'(0));
        check("clear_addr", 128'(addr_o), 128'(0));
        check("clear_tile", 128'(tile_idx_o), 128'(0));
        check("clear_size", 128'(trans_size_o), 128'(0));
        check("clear_busy", 128'(busy_o), 128'(0));
        check("clear_done", 128'(done_o), 128'(0));
        resp_flush = 1'b1;
        repeat (12) begin
            @(posedge clk_i);
            #1;
        end
        resp_flush = 1'b0;
        check("clear_stays_idle", 128'(busy_o), 128'(0));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [NT*AW-1:0] base;
        rst_ni     = 1'b0;
        clear_i    = 1'b0;
        start_i    = 1'b0;
        resp_flush = 1'b0;
        base_addr_i   = '0;
        trans_size_i  = '0;
        n_tiles_i     = '0;
        tile_stride_i = '0;
        set_resp(0, 0, 0, 0, 0, 0, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_req", 128'({sink_req_start_o, src_req_start_o}), 128'(0));
        check("rst_addr", 128'(addr_o), 128'(0));
        check("rst_tile", 128'(tile_idx_o), 128'(0));
        check("rst_size", 128'(trans_size_o), 128'(0));
        check("rst_busy", 128'(busy_o), 128'(0));
        check("rst_done", 128'(done_o), 128'(0));
        check("rst_state", 128'(dbg_state_o), 128'(0));
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        base = {32'h400, 32'h300, 32'h200, 32'h100};
        // single tile, immediate dones: exact latency
        run_job(base, 16'd8, 16'd1, 32'h20, 1'b1, 1'b0);
        // single tile, dones five cycles after the request
        set_resp(0, 0, 0, 0, 5, 5, 1'b0);
        run_job(base, 16'd8, 16'd1, 32'h20, 1'b0, 1'b0);
        // three tiles, stride 0x20, immediate dones
        set_resp(0, 0, 0, 0, 0, 0, 1'b0);
        run_job(base, 16'd8, 16'd3, 32'h20, 1'b1, 1'b0);
        // staggered ready: b late, sink later; a completes early
        set_resp(0, 4, 0, 6, 0, 0, 1'b0);
        run_job(base, 16'd12, 16'd2, 32'h20, 1'b0, 1'b0);
        // empty job
        set_resp(0, 0, 0, 0, 0, 0, 1'b0);
        run_job(base, 16'd5, 16'd0, 32'h20, 1'b1, 1'b0);
        // address wrap on the sink
        run_job({32'hFFFF_FFF0, 32'h300, 32'h200, 32'h100}, 16'd8, 16'd2, 32'h20, 1'b1, 1'b0);
        // clear in the WAIT of tile 1, then a noisy job
        clear_mid_job();
        set_resp(0, 2, 1, 3, 0, 4, 1'b1);
        run_job(base, 16'd7, 16'd3, 32'h100, 1'b0, 1'b1);

        // randomized jobs
        for (int j = 0; j < 10; j++) begin
            for (int k = 0; k < NT; k++) begin
                ready_lo[k] = 0;
                ready_hi[k] = int'($urandom_range(0, 5));
            end
            done_lo = 0;
            done_hi = int'($urandom_range(0, 6));
            spur_en = j[0];
            run_job({$urandom, $urandom, $urandom, $urandom}, SW'($urandom),
                    SW'($urandom_range(0, 4)), $urandom, 1'b0, j[0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
